// File: rtl/bank_r_pkg.sv
// rtl/bank_r_pkg.sv - shared defaults, register-zero address and address type for the register bank
package bank_r_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    // Address of the architectural zero register
    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/bank_r_scoreboard.sv
// rtl/bank_r_scoreboard.sv - per-register pending scoreboard with ready lookups and pending count
module bank_r_scoreboard
    import bank_r_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              res_en,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rdy1,
    output logic              rdy2,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_n;
    logic             res_ok;
    logic             clr_ok;
    logic             cnt_inc;
    logic             cnt_dec;

    // Qualify the reserve/clear requests: with a hardwired zero register they must not touch entry 0
    always_comb begin
        res_ok  = res_en && !(R0_ZERO && (res_addr == ADDR_W'(REG_ZERO)));
        clr_ok  = clr_en && !(R0_ZERO && (clr_addr == ADDR_W'(REG_ZERO)));
        cnt_inc = res_ok && !pend[res_addr];
        cnt_dec = clr_ok && pend[clr_addr] && !(res_ok && (res_addr == clr_addr));
    end

    // Next scoreboard state; a same-cycle reserve beats the clear because the new producer owns the register
    always_comb begin
        pend_n = pend;
        if (clr_ok) begin
            pend_n[clr_addr] = 1'b0;
        end
        if (res_ok) begin
            pend_n[res_addr] = 1'b1;
        end
        if (R0_ZERO) begin
            pend_n[0] = 1'b0;
        end
    end

    // Register scoreboard, up/down pending counter and ready flags taken from the post-edge state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_cnt <= '0;
            rdy1     <= 1'b0;
            rdy2     <= 1'b0;
        end else begin
            pend <= pend_n;
            if (cnt_inc && !cnt_dec) begin
                pend_cnt <= pend_cnt + 1'b1;
            end else if (cnt_dec && !cnt_inc) begin
                pend_cnt <= pend_cnt - 1'b1;
            end
            rdy1 <= ~pend_n[rd1_addr];
            rdy2 <= ~pend_n[rd2_addr];
        end
    end

endmodule

// File: rtl/bank_r_sb.sv
// rtl/bank_r_sb.sv - register bank with write-first bypassed read ports and pending scoreboard
module bank_r_sb
    import bank_r_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Rw,
    input  logic [ADDR_W-1:0] Dir,
    input  logic [DATA_W-1:0] DIn,
    input  logic              Res,
    input  logic [ADDR_W-1:0] ResDir,
    input  logic [ADDR_W-1:0] Rd1,
    input  logic [ADDR_W-1:0] Rd2,
    output logic [DATA_W-1:0] L1,
    output logic [DATA_W-1:0] L2,
    output logic              Rdy1,
    output logic              Rdy2,
    output logic [ADDR_W:0]   PendCnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] breg [DEPTH];
    logic              wr_ok;
    logic [DATA_W-1:0] byp1;
    logic [DATA_W-1:0] byp2;

    // Writes to the hardwired zero register are dropped
    always_comb begin
        wr_ok = Rw && !(R0_ZERO && (Dir == ADDR_W'(REG_ZERO)));
    end

    // Write-first bypass: a same-cycle write to the read address is forwarded instead of the stale array value
    always_comb begin
        if (R0_ZERO && (Rd1 == ADDR_W'(REG_ZERO))) begin
            byp1 = '0;
        end else if (Rw && (Dir == Rd1)) begin
            byp1 = DIn;
        end else begin
            byp1 = breg[Rd1];
        end
        if (R0_ZERO && (Rd2 == ADDR_W'(REG_ZERO))) begin
            byp2 = '0;
        end else if (Rw && (Dir == Rd2)) begin
            byp2 = DIn;
        end else begin
            byp2 = breg[Rd2];
        end
    end

    // Storage array write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                breg[i] <= '0;
            end
        end else if (wr_ok) begin
            breg[Dir] <= DIn;
        end
    end

    // Registered read data, one cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            L1 <= '0;
            L2 <= '0;
        end else begin
            L1 <= byp1;
            L2 <= byp2;
        end
    end

    bank_r_scoreboard #(
        .ADDR_W  (ADDR_W),
        .R0_ZERO (R0_ZERO)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_en   (Rw),
        .clr_addr (Dir),
        .res_en   (Res),
        .res_addr (ResDir),
        .rd1_addr (Rd1),
        .rd2_addr (Rd2),
        .rdy1     (Rdy1),
        .rdy2     (Rdy2),
        .pend_cnt (PendCnt)
    );

endmodule

// File: doc/bank_r_sb.md
Name: bank_r_sb

Overview:
- Parametrised successor to the datapath register bank.
- Clocked write port, two registered read ports with write-first bypass, register 0 hardwired to zero.
- Per-register pending scoreboard: the issue stage reserves a destination, the write-back stage clears it on write.
- Read ports return data plus a ready flag. The issue logic uses the ready flag for RAW stall decisions.

Parameters:
- DATA_W, 32, data width of every register.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- R0_ZERO, 1, 1 = register 0 always reads 0 and ignores writes and reserves; 0 = register 0 behaves like any other register.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rw  in  1  write enable.
- Dir  in  ADDR_W  write address.
- DIn  in  DATA_W  write data.
- Res  in  1  reserve enable; marks ResDir as pending.
- ResDir  in  ADDR_W  reserve address.
- Rd1  in  ADDR_W  read port 1 address.
- Rd2  in  ADDR_W  read port 2 address.
- L1  out  DATA_W  read port 1 data, registered.
- L2  out  DATA_W  read port 2 data, registered.
- Rdy1  out  1  register addressed by Rd1 is not pending, registered.
- Rdy2  out  1  register addressed by Rd2 is not pending, registered.
- PendCnt  out  ADDR_W+1  number of pending registers.

Behaviour:
- Reset (rst_n low, asynchronous, any time): all registers 0, all pending bits 0, L1=L2=0, Rdy1=Rdy2=0, PendCnt=0.
  - Reset mid-operation discards any in-flight write or reserve.
  - The first edge after deassertion behaves normally.
- Write: on a rising edge with Rw=1, BReg[Dir] <= DIn.
  - If R0_ZERO=1 and Dir=0, the write is dropped.
- Read, latency 1: on each edge, L1 <= bypass(Rd1) and L2 <= bypass(Rd2).
  - bypass(a) = 0 if R0_ZERO and a=0.
  - Else bypass(a) = DIn if Rw and Dir=a (write-first).
  - Else bypass(a) = BReg[a].
  - Reads happen every cycle; there is no read enable.
- Scoreboard next-state per register i: pend_n[i] = (pend[i] & ~(Rw & Dir==i)) | (Res & ResDir==i).
  - Reserve has priority over the clear on the same address in the same cycle: the new producer wins and the bit stays 1.
  - If R0_ZERO=1, pend[0] is constant 0; Res and Rw to address 0 have no scoreboard effect.
  - A write to a non-pending register is legal: data is updated, the pending bit is unchanged.
  - Reserving an already-pending register is legal: the bit stays 1 and the count is unchanged.
- Ready: Rdy1 <= ~pend_n[Rd1] and Rdy2 <= ~pend_n[Rd2].
  - Ready always reflects the post-edge scoreboard, so it is consistent with the bypassed data.
- PendCnt <= popcount(pend_n), maintained as an up/down counter:
  - +1 when the reserve sets a bit that was 0.
  - -1 when the write clears a bit that was 1 and the same address is not reserved that cycle.
  - Both events on different addresses: net 0.
  - Never exceeds 2**ADDR_W, or 2**ADDR_W-1 when R0_ZERO=1.
- No combinational path from any input to any output.

Decomposition:
- Shared package `bank_r_pkg`:
  - default DATA_W / ADDR_W localparams;
  - the REG_ZERO address constant (0);
  - a `reg_addr_t` typedef.
- One natural sub-module: `bank_r_scoreboard`. It owns pend[], pend_n, PendCnt and the ready lookups.
- Top level keeps the storage array, write logic and bypass muxes.

Test Plan:
- Reset then read: pulse rst_n low mid-cycle, Rd1=3, Rd2=0 -> L1=L2=0, Rdy1=Rdy2=0 while in reset; one edge after release, Rdy1=Rdy2=1, PendCnt=0.
- Write/read latency: cycle 0 Rw=1, Dir=5, DIn=32'hDEADBEEF, Rd1=5 -> L1=DEADBEEF after edge 0 (bypass); Rw=0 next cycle, Rd1=5 -> L1 still DEADBEEF (from array).
- Register zero: Rw=1, Dir=0, DIn=32'h1234, Res=1, ResDir=0, Rd1=0 -> L1=0, Rdy1=1, PendCnt=0.
- Scoreboard lifecycle: Res with ResDir=7 -> PendCnt=1; Rd2=7 -> Rdy2=0; later Rw, Dir=7, DIn=42 with Rd2=7 -> same edge L2=42, Rdy2=1, PendCnt=0.
- Simultaneous reserve and write, same address: 9 pending, Res=1, ResDir=9, Rw=1, Dir=9 -> data written, pend[9] stays 1, PendCnt unchanged, Rdy for 9 = 0.
- Simultaneous reserve and write, different addresses: 4 pending, Res to 6, Rw to 4 -> PendCnt unchanged at 1, Rdy(4)=1, Rdy(6)=0; then reserve all 31 non-zero registers -> PendCnt=31, with no overflow.
